// File: rtl/rtype_alu_arbiter.sv
// Round-robin front end sharing one combinational R-type ALU among NREQ requesters.
// Requests are credit-limited so each requester's response FIFO can never overflow.
module rtype_alu_arbiter #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_func,
    input  logic [32*NREQ-1:0]   req_rv1,
    input  logic [32*NREQ-1:0]   req_rv2,
    input  logic [TAGW*NREQ-1:0] req_tag,
    output logic [31:0]          alu_idata,
    output logic [31:0]          alu_rv1,
    output logic [31:0]          alu_rv2,
    input  logic [31:0]          alu_result,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_data,
    output logic [TAGW*NREQ-1:0] rsp_tag,
    output logic [NREQ-1:0]      rsp_err
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and an offered response holds until it is taken.
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt  [NREQ];
    logic [CW-1:0]   fcnt [NREQ];
    logic [AW-1:0]   wp   [NREQ];
    logic [AW-1:0]   rp   [NREQ];
    logic [31:0]     fdata [NREQ][DEPTH];
    logic [TAGW-1:0] ftag  [NREQ][DEPTH];
    logic            ferr  [NREQ][DEPTH];

    logic            iss_v;
    logic [PW-1:0]   iss_own;
    logic [4:0]      iss_func;
    logic [31:0]     iss_rv1;
    logic [31:0]     iss_rv2;
    logic [TAGW-1:0] iss_tag;
    logic            iss_ill;

    logic [NREQ-1:0] rsp_hs;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] push;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [4:0]      gnt_func;
    logic            alu_on;
    logic [31:0]     wb_data;

    function automatic logic func_legal(input logic [4:0] f);
        case (f)
            5'b00000, 5'b10000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b10101, 5'b00110, 5'b00111: func_legal = 1'b1;
            default:                                           func_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        ptr_next = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rsp_hs = rsp_valid & rsp_ready;

    // A full requester stays eligible when its head response leaves this same cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = !rst && req_valid[i] &&
                      ((cnt[i] < CW'(DEPTH)) || ((cnt[i] == CW'(DEPTH)) && rsp_hs[i]));
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && elig[(int'(ptr) + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((int'(ptr) + k) % NREQ);
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign req_ready = gnt;
    assign gnt_func  = req_func[gnt_idx*5 +: 5];

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_v    <= 1'b0;
            iss_own  <= '0;
            iss_func <= '0;
            iss_rv1  <= '0;
            iss_rv2  <= '0;
            iss_tag  <= '0;
            iss_ill  <= 1'b0;
        end else begin
            iss_v <= gnt_any;
            if (gnt_any) begin
                iss_own  <= gnt_idx;
                iss_func <= gnt_func;
                iss_rv1  <= req_rv1[gnt_idx*32 +: 32];
                iss_rv2  <= req_rv2[gnt_idx*32 +: 32];
                iss_tag  <= req_tag[gnt_idx*TAGW +: TAGW];
                iss_ill  <= !func_legal(gnt_func);
            end
        end
    end

    // Illegal codes never reach the ALU; the ALU sees an all-zero word instead.
    assign alu_on    = iss_v && !iss_ill;
    assign alu_idata = alu_on ? {1'b0, iss_func[4], 4'b0, iss_func[3], 10'b0, iss_func[2:0], 12'b0}
                              : 32'h0;
    assign alu_rv1   = alu_on ? iss_rv1 : 32'h0;
    assign alu_rv2   = alu_on ? iss_rv2 : 32'h0;
    assign wb_data   = iss_ill ? 32'h0 : alu_result;

    always_comb begin
        push = '0;
        for (int i = 0; i < NREQ; i++) begin
            push[i] = iss_v && (iss_own == PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cnt[i]  <= '0;
                fcnt[i] <= '0;
                wp[i]   <= '0;
                rp[i]   <= '0;
            end
        end else begin
            if (gnt_any) ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                cnt[i]  <= cnt[i] + CW'(gnt[i]) - CW'(rsp_hs[i]);
                fcnt[i] <= fcnt[i] + CW'(push[i]) - CW'(rsp_hs[i]);
                if (push[i])   wp[i] <= ptr_next(wp[i]);
                if (rsp_hs[i]) rp[i] <= ptr_next(rp[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                fdata[i][wp[i]] <= wb_data;
                ftag[i][wp[i]]  <= iss_tag;
                ferr[i][wp[i]]  <= iss_ill;
            end
        end
    end

    // Outputs are masked when empty so stale storage never shows after reset.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_tag   = '0;
        rsp_err   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (fcnt[i] != '0) begin
                rsp_valid[i]            = 1'b1;
                rsp_data[i*32 +: 32]    = fdata[i][rp[i]];
                rsp_tag[i*TAGW +: TAGW] = ftag[i][rp[i]];
                rsp_err[i]              = ferr[i][rp[i]];
            end
        end
    end
endmodule

// File: tb/tb_rtype_alu_arbiter.sv
// Randomized and directed bench for rtype_alu_arbiter with a transaction-level
// reference model (credit counts, round-robin pointer, per-requester result queues).
module tb_rtype_alu_arbiter;
    localparam int N     = 2;
    localparam int DEPTH = 2;
    localparam int TAGW  = 4;
    localparam int EW    = 32 + 1 + TAGW + 32;
    localparam int TARGET_OPS = 10000;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [5*N-1:0]    req_func;
    logic [32*N-1:0]   req_rv1;
    logic [32*N-1:0]   req_rv2;
    logic [TAGW*N-1:0] req_tag;
    logic [31:0]       alu_idata;
    logic [31:0]       alu_rv1;
    logic [31:0]       alu_rv2;
    logic [31:0]       alu_result;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready;
    logic [32*N-1:0]   rsp_data;
    logic [TAGW*N-1:0] rsp_tag;
    logic [N-1:0]      rsp_err;

    rtype_alu_arbiter #(.NREQ(N), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_rv1(req_rv1), .req_rv2(req_rv2), .req_tag(req_tag),
        .alu_idata(alu_idata), .alu_rv1(alu_rv1), .alu_rv2(alu_rv2), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference arithmetic ----------------
    // Returns {illegal, result} for a 5-bit function code.
    function automatic logic [32:0] ref_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = '0;
        case (f)
            5'b00000: r[31:0] = a + b;
            5'b10000: r[31:0] = a - b;
            5'b00001: r[31:0] = a << b[4:0];
            5'b00010: r[31:0] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'b00011: r[31:0] = (a < b) ? 32'd1 : 32'd0;
            5'b00100: r[31:0] = a ^ b;
            5'b00101: r[31:0] = a >> b[4:0];
            5'b10101: r[31:0] = $unsigned($signed(a) >>> b[4:0]);
            5'b00110: r[31:0] = a | b;
            5'b00111: r[31:0] = a & b;
            default:  r[32]   = 1'b1;
        endcase
        return r;
    endfunction

    // The ALU outside the arbiter: decode the instruction word and compute.
    logic [32:0] alu_calc;
    always_comb begin
        alu_calc   = ref_op({alu_idata[30], alu_idata[25], alu_idata[14:12]}, alu_rv1, alu_rv2);
        alu_result = alu_calc[31:0];
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miscmp = n_miscmp + 1;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    logic [EW-1:0] exp_q [N][$];
    logic [31:0]   got_q [N][$];
    int            mcnt [N];
    int            acc_cnt [N];
    logic [N-1:0]  took;
    int            mptr;
    int            n_acc;
    int            hs_cnt;
    logic          prev_v;
    logic          prev_ill;
    logic [4:0]    prev_f;
    logic [31:0]   prev_a;
    logic [31:0]   prev_b;
    logic [N-1:0]  ev;
    logic [N-1:0]  eg;
    int            gi;
    int            idx;
    logic [31:0]   e_idata;
    logic [31:0]   e_a;
    logic [31:0]   e_b;
    logic [EW-1:0] ent;
    logic [32:0]   r;
    logic [4:0]    mf;
    logic [31:0]   ma;
    logic [31:0]   mb;
    logic [TAGW-1:0] mt;

    initial begin
        mptr = 0; n_acc = 0; hs_cnt = 0; prev_v = 1'b0; took = '0;
        for (int i = 0; i < N; i++) begin mcnt[i] = 0; acc_cnt[i] = 0; end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_ready", {62'b0, req_ready}, 64'h0);
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
                mcnt[i] = 0;
            end
            mptr   = 0;
            prev_v = 1'b0;
        end else begin
            // a result becomes visible two cycles after its accept
            for (int i = 0; i < N; i++) begin
                ev[i] = (exp_q[i].size() > 0) && (int'(exp_q[i][0][EW-1 -: 32]) + 2 <= cyc);
                check("rsp_valid", {63'b0, rsp_valid[i]}, {63'b0, ev[i]});
            end

            e_idata = '0; e_a = '0; e_b = '0;
            if (prev_v && !prev_ill) begin
                e_idata[30]    = prev_f[4];
                e_idata[25]    = prev_f[3];
                e_idata[14:12] = prev_f[2:0];
                e_a = prev_a;
                e_b = prev_b;
            end
            check("alu_idata", {32'b0, alu_idata}, {32'b0, e_idata});
            check("alu_rv1", {32'b0, alu_rv1}, {32'b0, e_a});
            check("alu_rv2", {32'b0, alu_rv2}, {32'b0, e_b});

            eg = '0; gi = 0;
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (eg == '0 && req_valid[idx] &&
                    (mcnt[idx] < DEPTH || (mcnt[idx] == DEPTH && ev[idx] && rsp_ready[idx]))) begin
                    eg[idx] = 1'b1;
                    gi = idx;
                end
            end
            check("grant", {62'b0, req_ready}, {62'b0, eg});

            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    hs_cnt = hs_cnt + 1;
                    if (exp_q[i].size() == 0) begin
                        check("rsp_spurious", 64'(exp_q[i].size()), 64'd1);
                    end else begin
                        ent = exp_q[i].pop_front();
                        check("rsp_word", {27'b0, rsp_err[i], rsp_tag[i*TAGW +: TAGW], rsp_data[i*32 +: 32]},
                              {27'b0, ent[32+TAGW:0]});
                        mcnt[i] = mcnt[i] - 1;
                        got_q[i].push_back(rsp_data[i*32 +: 32]);
                    end
                end
            end

            prev_v = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    mf = req_func[i*5 +: 5];
                    ma = req_rv1[i*32 +: 32];
                    mb = req_rv2[i*32 +: 32];
                    mt = req_tag[i*TAGW +: TAGW];
                    r  = ref_op(mf, ma, mb);
                    exp_q[i].push_back({32'(cyc), r[32], mt, r[31:0]});
                    mcnt[i] = mcnt[i] + 1;
                    acc_cnt[i] = acc_cnt[i] + 1;
                    took[i] = 1'b1;
                    n_acc = n_acc + 1;
                    prev_v = 1'b1; prev_f = mf; prev_a = ma; prev_b = mb; prev_ill = r[32];
                end
            end
            // the response FIFO must never be pushed while full
            for (int i = 0; i < N; i++) begin
                check("credit", {63'b0, (mcnt[i] <= DEPTH)}, 64'd1);
            end
            if (eg != '0) mptr = (gi + 1) % N;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAGW-1:0] t);
        req_valid[i]           = 1'b1;
        req_func[i*5 +: 5]     = f;
        req_rv1[i*32 +: 32]    = a;
        req_rv2[i*32 +: 32]    = b;
        req_tag[i*TAGW +: TAGW] = t;
    endtask

    function automatic logic [4:0] legal_code(input int k);
        case (k)
            0: legal_code = 5'b00000;  1: legal_code = 5'b10000;
            2: legal_code = 5'b00001;  3: legal_code = 5'b00010;
            4: legal_code = 5'b00011;  5: legal_code = 5'b00100;
            6: legal_code = 5'b00101;  7: legal_code = 5'b10101;
            8: legal_code = 5'b00110;  default: legal_code = 5'b00111;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: rand_word = 32'h0;
            1: rand_word = 32'hFFFF_FFFF;
            2: rand_word = 32'h8000_0000;
            3: rand_word = 32'h7FFF_FFFF;
            4: rand_word = 32'($urandom_range(0, 40));
            default: rand_word = $urandom;
        endcase
    endfunction

    task automatic drive_random();
        logic [4:0] f;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || took[i]) begin
                took[i] = 1'b0;
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 15) == 0) f = 5'($urandom_range(0, 31));
                    else f = legal_code($urandom_range(0, 9));
                    set_req(i, f, rand_word(), rand_word(), TAGW'($urandom_range(0, 15)));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready[i] = ($urandom_range(0, 1) == 1);
        end
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        repeat (6) step();
    endtask

    // ---------------- stimulus ----------------
    int guard;

    initial begin
        rst = 1'b1;
        req_valid = '0; req_func = '0; req_rv1 = '0; req_rv2 = '0; req_tag = '0;
        rsp_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_req_ready", {62'b0, req_ready}, 64'h0);
        check("reset_rsp_valid", {62'b0, rsp_valid}, 64'h0);
        check("reset_rsp_data", rsp_data, 64'h0);
        check("reset_rsp_tag", {56'b0, rsp_tag}, 64'h0);
        check("reset_rsp_err", {62'b0, rsp_err}, 64'h0);
        check("reset_alu", {alu_idata, alu_rv1 | alu_rv2}, 64'h0);
        check("reset_ptr", 64'(dut.ptr), 64'h0);

        // single ADD with two-cycle latency
        step();
        rsp_ready = '1;
        set_req(0, 5'b00000, 32'h7FFF_FFFF, 32'h1, 4'd3);
        @(negedge clk);
        check("add_accept", {62'b0, req_ready}, 64'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("add_alu_rv1", {32'b0, alu_rv1}, 64'h7FFF_FFFF);
        check("add_alu_rv2", {32'b0, alu_rv2}, 64'h1);
        check("add_rsp_early", {63'b0, rsp_valid[0]}, 64'h0);
        step();
        @(negedge clk);
        check("add_rsp_valid", {63'b0, rsp_valid[0]}, 64'h1);
        check("add_rsp_data", {32'b0, rsp_data[31:0]}, 64'h8000_0000);
        check("add_rsp_tag", {60'b0, rsp_tag[TAGW-1:0]}, 64'h3);
        check("add_rsp_err", {63'b0, rsp_err[0]}, 64'h0);
        step();

        // fair alternation from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        got_q[0].delete(); got_q[1].delete();
        for (int k = 0; k < 4; k++) begin
            set_req(0, (k == 0) ? 5'b00011 : 5'b00010, 32'h1, 32'hFFFF_FFFF, 4'd1);
            set_req(1, 5'b10101, 32'h8000_0000, 32'd4, 4'd2);
            @(negedge clk);
            check("rr_grant", {62'b0, req_ready}, (k % 2 == 0) ? 64'h1 : 64'h2);
            step();
        end
        drain();
        check("rr_req0_count", 64'(got_q[0].size()), 64'd2);
        check("rr_req1_count", 64'(got_q[1].size()), 64'd2);
        if (got_q[0].size() == 2 && got_q[1].size() == 2) begin
            check("sltu_result", {32'b0, got_q[0][0]}, 64'h1);
            check("slt_result", {32'b0, got_q[0][1]}, 64'h0);
            check("sra_result", {32'b0, got_q[1][0]}, 64'hF800_0000);
        end

        // back-pressure on req0: credits cap it at DEPTH
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        rsp_ready = 2'b10;
        set_req(0, 5'b00100, 32'hA5A5_0F0F, 32'h0FF0_1234, 4'd7);
        set_req(1, 5'b00110, 32'h1111_0000, 32'h0000_2222, 4'd9);
        repeat (8) begin
            @(negedge clk);
            step();
        end
        check("bp_req0_accepts", 64'(acc_cnt[0]), 64'(DEPTH));
        check("bp_req1_accepts", 64'(acc_cnt[1]), 64'd6);
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp_bypass_accept", {63'b0, req_ready[0]}, 64'h1);
        step();
        rsp_ready = 2'b10;
        drain();

        // illegal code on req1
        set_req(1, 5'b01000, 32'h1234_5678, 32'h9ABC_DEF0, 4'd5);
        @(negedge clk);
        check("ill_accept", {62'b0, req_ready}, 64'h2);
        step();
        req_valid = '0;
        @(negedge clk);
        check("ill_alu_idata", {32'b0, alu_idata}, 64'h0);
        check("ill_alu_ops", {alu_rv1, alu_rv2}, 64'h0);
        step();
        @(negedge clk);
        check("ill_rsp_valid", {63'b0, rsp_valid[1]}, 64'h1);
        check("ill_rsp_err", {63'b0, rsp_err[1]}, 64'h1);
        check("ill_rsp_data", {32'b0, rsp_data[63:32]}, 64'h0);
        check("ill_rsp_tag", {60'b0, rsp_tag[2*TAGW-1:TAGW]}, 64'h5);
        step();
        acc_cnt[1] = 0;
        rsp_ready = 2'b01;
        set_req(1, 5'b00000, 32'd10, 32'd20, 4'd6);
        repeat (6) begin
            @(negedge clk);
            step();
        end
        check("ill_credit_back", 64'(acc_cnt[1]), 64'(DEPTH));
        drain();

        // reset with work in flight and buffered
        rsp_ready = '0;
        set_req(0, 5'b00001, 32'h1, 32'd5, 4'd1);
        set_req(1, 5'b10000, 32'd9, 32'd3, 4'd2);
        repeat (3) step();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_rsp_valid", {62'b0, rsp_valid}, 64'h0);
        check("rstmid_rsp_data", rsp_data, 64'h0);
        check("rstmid_rsp_tag_err", {54'b0, rsp_tag, rsp_err}, 64'h0);
        check("rstmid_req_ready", {62'b0, req_ready}, 64'h0);
        check("rstmid_alu", {alu_idata, alu_rv1 | alu_rv2}, 64'h0);
        check("rstmid_ptr", 64'(dut.ptr), 64'h0);
        hs_cnt = 0;
        rsp_ready = '1;
        repeat (6) step();
        check("rstmid_no_stale", 64'(hs_cnt), 64'h0);

        // randomized traffic
        took = '0;
        n_acc = 0;
        guard = 0;
        while (n_acc < TARGET_OPS && guard < 30000) begin
            drive_random();
            step();
            guard = guard + 1;
        end
        check("rand_budget", {63'b0, (n_acc >= TARGET_OPS)}, 64'h1);
        req_valid = '0;
        rsp_ready = '1;
        repeat (20) step();
        check("rand_drain_q0", 64'(exp_q[0].size()), 64'h0);
        check("rand_drain_q1", 64'(exp_q[1].size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
